// File: rtl/egress_rr_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// egress_rr_scheduler_pkg
// Shared constants and types for the egress round-robin read scheduler:
//   DEF_PORT_NUB_TOTAL : default number of switch ports (also the number of
//                        sub-queues per output VOQ)
//   DEF_DATA_WIDTH     : default payload width of the switch read data
//   DEF_WIDTH_SEL      : width of a sub-queue index
//   eng_state_e        : per-port engine state encoding
// -----------------------------------------------------------------------------
package egress_rr_scheduler_pkg;

    localparam int DEF_PORT_NUB_TOTAL = 4;
    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_WIDTH_SEL      = $clog2(DEF_PORT_NUB_TOTAL);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_VALID = 2'd2
    } eng_state_e;

endpackage

// File: rtl/egress_rr_scheduler_if.sv
// -----------------------------------------------------------------------------
// egress_rr_scheduler_if
// Bundles the switch-side read port and the egress-side valid/ready port.
//   empty     : N*N   bit [i*N+j] = output i sub-queue j empty
//   port_out  : N*DW  switch read data, slice i for output i
//   rd_sel    : N*SW  sub-queue to read, slice i for output i
//   rd_en     : N     one-cycle read strobe per output
//   out_data  : N*DW  egress data per port
//   out_valid : N     egress valid per port
//   out_ready : N     egress ready per port
//   out_src   : N*SW  sub-queue index the egress word came from
// master = scheduler side, slave = switch + MAC side.
// -----------------------------------------------------------------------------
interface egress_rr_scheduler_if
    import egress_rr_scheduler_pkg::*;
#(
    parameter int N          = DEF_PORT_NUB_TOTAL,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SEL_W      = $clog2(N)
) ();

    logic [N*N-1:0]          empty;
    logic [N*DATA_WIDTH-1:0] port_out;
    logic [N*SEL_W-1:0]      rd_sel;
    logic [N-1:0]            rd_en;
    logic [N*DATA_WIDTH-1:0] out_data;
    logic [N-1:0]            out_valid;
    logic [N-1:0]            out_ready;
    logic [N*SEL_W-1:0]      out_src;

    modport master (
        input  empty, port_out, out_ready,
        output rd_sel, rd_en, out_data, out_valid, out_src
    );

    modport slave (
        output empty, port_out, out_ready,
        input  rd_sel, rd_en, out_data, out_valid, out_src
    );

endinterface

// File: rtl/egress_port_engine.sv
// -----------------------------------------------------------------------------
// egress_port_engine
// Single-output read engine: round-robin picks a non-empty sub-queue, pulses
// rd_en/rd_sel for one cycle, waits RD_LATENCY cycles, captures the returned
// word and holds it under a valid/ready handshake.
//   clk, rst_n : clock, async active-low reset
//   empty      : N     sub-queue empty flags of this output
//   port_out   : DW    switch read data of this output
//   out_ready  : 1     downstream ready
//   rd_sel     : SW    sub-queue being read (holds between reads)
//   rd_en      : 1     one-cycle read strobe
//   out_data   : DW    captured word
//   out_valid  : 1     captured word valid
//   out_src    : SW    sub-queue the captured word came from
// -----------------------------------------------------------------------------
module egress_port_engine
    import egress_rr_scheduler_pkg::*;
#(
    parameter int N          = DEF_PORT_NUB_TOTAL,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RD_LATENCY = 1,
    parameter int SEL_W      = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          empty,
    input  logic [DATA_WIDTH-1:0] port_out,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      rd_sel,
    output logic                  rd_en,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic [SEL_W-1:0]      out_src
);

    localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LATENCY - 1);

    // Returns {found, index}: first set bit of req scanning ptr, ptr+1, ...
    // Scanning offsets from high to low lets the lowest offset win.
    function automatic logic [SEL_W:0] rr_pick(input logic [N-1:0] req,
                                                input logic [SEL_W-1:0] ptr);
        logic [SEL_W:0]   result;
        logic [SEL_W-1:0] idx;
        result = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = SEL_W'((int'(ptr) + k) % N);
            if (req[idx]) begin
                result = {1'b1, idx};
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    eng_state_e            state_r;
    logic [SEL_W-1:0]      rr_ptr_r;
    logic [LAT_W-1:0]      lat_cnt_r;
    logic [SEL_W-1:0]      rd_sel_r;
    logic                  rd_en_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic                  out_valid_r;
    logic [SEL_W-1:0]      out_src_r;

    logic [SEL_W:0]        pick_s;
    logic                  grant_valid_s;
    logic [SEL_W-1:0]      grant_s;
    logic [SEL_W-1:0]      next_ptr_s;

    // Round-robin grant over the non-empty sub-queues and the pointer after it.
    always_comb begin
        pick_s        = rr_pick(~empty, rr_ptr_r);
        grant_valid_s = pick_s[SEL_W];
        grant_s       = pick_s[SEL_W-1:0];
        if (grant_s == SEL_W'(N - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = grant_s + SEL_W'(1);
        end
    end

    // Engine FSM: issue read, wait for data, hold until handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= '0;
            lat_cnt_r   <= '0;
            rd_sel_r    <= '0;
            rd_en_r     <= 1'b0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            out_src_r   <= '0;
        end else begin
            // rd_en is a single-cycle strobe; only the grant branch raises it.
            rd_en_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_valid_s) begin
                        rd_en_r   <= 1'b1;
                        rd_sel_r  <= grant_s;
                        out_src_r <= grant_s;
                        rr_ptr_r  <= next_ptr_s;
                        lat_cnt_r <= '0;
                        state_r   <= ST_WAIT;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                // The strobe cycle itself is the first latency cycle, so the
                // word is captured as it becomes valid and shown one cycle later.
                ST_WAIT: begin
                    if (lat_cnt_r == LAT_LAST) begin
                        out_data_r  <= port_out;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_VALID;
                    end else begin
                        lat_cnt_r   <= lat_cnt_r + LAT_W'(1);
                    end
                end
                ST_VALID: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_VALID;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_sel    = rd_sel_r;
    assign rd_en     = rd_en_r;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign out_src   = out_src_r;

endmodule

// File: rtl/egress_rr_scheduler.sv
// -----------------------------------------------------------------------------
// egress_rr_scheduler
// Output-side read scheduler for the shared-memory switch: one independent
// egress_port_engine per output port, plus bus slicing.
//   clk   : system clock
//   rst_n : async active-low reset
//   bus   : egress_rr_scheduler_if.master (switch read port + egress port)
// -----------------------------------------------------------------------------
module egress_rr_scheduler
    import egress_rr_scheduler_pkg::*;
#(
    parameter int PORT_NUB_TOTAL = DEF_PORT_NUB_TOTAL,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int RD_LATENCY     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    egress_rr_scheduler_if.master bus
);

    localparam int N         = PORT_NUB_TOTAL;
    localparam int WIDTH_SEL = $clog2(PORT_NUB_TOTAL);

    logic [N-1:0][WIDTH_SEL-1:0]  rd_sel_s;
    logic [N-1:0]                 rd_en_s;
    logic [N-1:0][DATA_WIDTH-1:0] out_data_s;
    logic [N-1:0]                 out_valid_s;
    logic [N-1:0][WIDTH_SEL-1:0]  out_src_s;

    for (genvar i = 0; i < N; i++) begin : g_port
        egress_port_engine #(
            .N          (N),
            .DATA_WIDTH (DATA_WIDTH),
            .RD_LATENCY (RD_LATENCY),
            .SEL_W      (WIDTH_SEL)
        ) u_engine (
            .clk       (clk),
            .rst_n     (rst_n),
            .empty     (bus.empty[i*N +: N]),
            .port_out  (bus.port_out[i*DATA_WIDTH +: DATA_WIDTH]),
            .out_ready (bus.out_ready[i]),
            .rd_sel    (rd_sel_s[i]),
            .rd_en     (rd_en_s[i]),
            .out_data  (out_data_s[i]),
            .out_valid (out_valid_s[i]),
            .out_src   (out_src_s[i])
        );
    end

    assign bus.rd_sel    = rd_sel_s;
    assign bus.rd_en     = rd_en_s;
    assign bus.out_data  = out_data_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_src   = out_src_s;

endmodule

// File: tb/tb_egress_rr_scheduler.sv
module tb_egress_rr_scheduler;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int SW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    egress_rr_scheduler_if #(.N(N), .DATA_WIDTH(DW), .SEL_W(SW)) bus ();

    egress_rr_scheduler #(
        .PORT_NUB_TOTAL (N),
        .DATA_WIDTH     (DW),
        .RD_LATENCY     (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n         = 1'b0;
        bus.empty     = '1;
        bus.port_out  = '0;
        bus.out_ready = '1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    function automatic int ref_pick(input logic [3:0] nonempty, input int ptr);
        for (int j = 0; j < 4; j++) begin
            if (nonempty[(ptr + j) % 4]) return (ptr + j) % 4;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.empty     = 16'h0000;
        bus.port_out  = 32'hFFFF_FFFF;
        bus.out_ready = 4'hF;
        step();
        n_cmp++; if (bus.rd_en !== 4'h0) begin n_err++; $display("FAIL reset_rd_en: got %h expected 0", bus.rd_en); end
        n_cmp++; if (bus.rd_sel !== 8'h00) begin n_err++; $display("FAIL reset_rd_sel: got %h expected 0", bus.rd_sel); end
        n_cmp++; if (bus.out_valid !== 4'h0) begin n_err++; $display("FAIL reset_out_valid: got %h expected 0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data); end
        n_cmp++; if (bus.out_src !== 8'h00) begin n_err++; $display("FAIL reset_out_src: got %h expected 0", bus.out_src); end
        rst_n = 1'b1;
    endtask

    task automatic test_idle_no_traffic();
        apply_reset();
        for (int c = 0; c < 20; c++) begin
            step();
            n_cmp++; if (bus.rd_en !== 4'h0) begin n_err++; $display("FAIL idle_rd_en c%0d: got %h expected 0", c, bus.rd_en); end
            n_cmp++; if (bus.out_valid !== 4'h0) begin n_err++; $display("FAIL idle_out_valid c%0d: got %h expected 0", c, bus.out_valid); end
            n_cmp++; if (bus.rd_sel !== 8'h00) begin n_err++; $display("FAIL idle_rd_sel c%0d: got %h expected 0", c, bus.rd_sel); end
        end
    endtask

    task automatic test_single_read();
        apply_reset();
        bus.empty    = 16'hFFFB;
        bus.port_out = 32'h0000_00A5;
        step();
        n_cmp++; if (bus.rd_en !== 4'b0001) begin n_err++; $display("FAIL single_rd_en: got %b expected 0001", bus.rd_en); end
        n_cmp++; if (bus.rd_sel[1:0] !== 2'd2) begin n_err++; $display("FAIL single_rd_sel: got %0d expected 2", bus.rd_sel[1:0]); end
        n_cmp++; if (bus.out_valid[0] !== 1'b0) begin n_err++; $display("FAIL single_early_valid: got %b expected 0", bus.out_valid[0]); end
        bus.empty = 16'hFFFF;
        step();
        n_cmp++; if (bus.out_valid !== 4'b0001) begin n_err++; $display("FAIL single_out_valid: got %b expected 0001", bus.out_valid); end
        n_cmp++; if (bus.out_data[7:0] !== 8'hA5) begin n_err++; $display("FAIL single_out_data: got %h expected a5", bus.out_data[7:0]); end
        n_cmp++; if (bus.out_src[1:0] !== 2'd2) begin n_err++; $display("FAIL single_out_src: got %0d expected 2", bus.out_src[1:0]); end
        n_cmp++; if (bus.rd_en[0] !== 1'b0) begin n_err++; $display("FAIL single_rd_en_pulse: got %b expected 0", bus.rd_en[0]); end
        step();
        n_cmp++; if (bus.out_valid[0] !== 1'b0) begin n_err++; $display("FAIL single_after_hs: got %b expected 0", bus.out_valid[0]); end
        step();
        n_cmp++; if (bus.rd_en[0] !== 1'b0) begin n_err++; $display("FAIL single_no_reread: got %b expected 0", bus.rd_en[0]); end
    endtask

    task automatic test_rr_order();
        logic exp_en;
        logic [1:0] exp_sel;
        apply_reset();
        bus.empty = 16'hFF0F;
        for (int c = 1; c <= 13; c++) begin
            step();
            exp_en = (c % 3 == 1);
            n_cmp++; if (bus.rd_en[1] !== exp_en) begin n_err++; $display("FAIL rr_rd_en c%0d: got %b expected %b", c, bus.rd_en[1], exp_en); end
            n_cmp++; if ((bus.rd_en & 4'b1101) !== 4'b0000) begin n_err++; $display("FAIL rr_other_ports c%0d: got %b expected 0000", c, bus.rd_en); end
            if (exp_en) begin
                exp_sel = 2'(((c - 1) / 3) % 4);
                n_cmp++; if (bus.rd_sel[3:2] !== exp_sel) begin n_err++; $display("FAIL rr_grant c%0d: got %0d expected %0d", c, bus.rd_sel[3:2], exp_sel); end
            end
        end
    endtask

    task automatic test_back_pressure();
        apply_reset();
        bus.empty     = 16'hFDFF;
        bus.port_out  = 32'h003C_0000;
        bus.out_ready = 4'b1011;
        step();
        n_cmp++; if (bus.rd_en[2] !== 1'b1 || bus.rd_sel[5:4] !== 2'd1) begin n_err++; $display("FAIL bp_grant: got en=%b sel=%0d expected en=1 sel=1", bus.rd_en[2], bus.rd_sel[5:4]); end
        step();
        bus.port_out = 32'h00C3_0000;
        for (int c = 0; c < 10; c++) begin
            n_cmp++; if (bus.out_valid[2] !== 1'b1) begin n_err++; $display("FAIL bp_valid c%0d: got %b expected 1", c, bus.out_valid[2]); end
            n_cmp++; if (bus.out_data[23:16] !== 8'h3C) begin n_err++; $display("FAIL bp_data c%0d: got %h expected 3c", c, bus.out_data[23:16]); end
            n_cmp++; if (bus.out_src[5:4] !== 2'd1) begin n_err++; $display("FAIL bp_src c%0d: got %0d expected 1", c, bus.out_src[5:4]); end
            n_cmp++; if (bus.rd_en[2] !== 1'b0) begin n_err++; $display("FAIL bp_rd_en c%0d: got %b expected 0", c, bus.rd_en[2]); end
            step();
        end
        bus.out_ready[2] = 1'b1;
        bus.empty        = 16'hFFFF;
        n_cmp++; if (bus.out_valid[2] !== 1'b1) begin n_err++; $display("FAIL bp_valid_at_ready: got %b expected 1", bus.out_valid[2]); end
        step();
        n_cmp++; if (bus.out_valid[2] !== 1'b0) begin n_err++; $display("FAIL bp_single_xfer: got %b expected 0", bus.out_valid[2]); end
        step();
        n_cmp++; if (bus.out_valid[2] !== 1'b0 || bus.rd_en[2] !== 1'b0) begin n_err++; $display("FAIL bp_quiet: got valid=%b en=%b expected 0 0", bus.out_valid[2], bus.rd_en[2]); end
    endtask

    task automatic test_reset_in_wait();
        apply_reset();
        bus.empty    = 16'hDFFF;
        bus.port_out = 32'h7700_0000;
        step();
        n_cmp++; if (bus.rd_en[3] !== 1'b1 || bus.rd_sel[7:6] !== 2'd1) begin n_err++; $display("FAIL rw_grant: got en=%b sel=%0d expected en=1 sel=1", bus.rd_en[3], bus.rd_sel[7:6]); end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.rd_en !== 4'h0) begin n_err++; $display("FAIL rw_rd_en: got %h expected 0", bus.rd_en); end
        n_cmp++; if (bus.rd_sel !== 8'h00) begin n_err++; $display("FAIL rw_rd_sel: got %h expected 0", bus.rd_sel); end
        n_cmp++; if (bus.out_valid !== 4'h0) begin n_err++; $display("FAIL rw_out_valid: got %h expected 0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 32'h0 || bus.out_src !== 8'h00) begin n_err++; $display("FAIL rw_out_data_src: got %h/%h expected 0/0", bus.out_data, bus.out_src); end
        bus.empty = 16'hAFFF;
        step();
        n_cmp++; if (bus.out_valid[3] !== 1'b0) begin n_err++; $display("FAIL rw_discard: got %b expected 0", bus.out_valid[3]); end
        rst_n = 1'b1;
        step();
        n_cmp++; if (bus.rd_en[3] !== 1'b1 || bus.rd_sel[7:6] !== 2'd0) begin n_err++; $display("FAIL rw_restart: got en=%b sel=%0d expected en=1 sel=0", bus.rd_en[3], bus.rd_sel[7:6]); end
        bus.empty = 16'hFFFF;
        step();
        n_cmp++; if (bus.out_valid[3] !== 1'b1 || bus.out_src[7:6] !== 2'd0 || bus.out_data[31:24] !== 8'h77) begin n_err++; $display("FAIL rw_after: got v=%b src=%0d d=%h expected 1 0 77", bus.out_valid[3], bus.out_src[7:6], bus.out_data[31:24]); end
    endtask

    task automatic test_all_ports();
        int         ptr [4];
        logic       busy [4];
        logic       was_idle;
        logic       exp_en;
        logic [7:0] exp_data [4];
        logic [1:0] exp_src [4];
        int         grants [4];
        logic [3:0] ne [4];
        logic [3:0] ne_drv [4];
        logic [3:0] ready_drv;
        logic [3:0] valid_prev;
        int         g;
        apply_reset();
        for (int p = 0; p < 4; p++) begin
            ptr[p] = 0; busy[p] = 1'b0; grants[p] = 0; exp_data[p] = 8'h00; exp_src[p] = 2'd0;
        end
        valid_prev = 4'h0;
        for (int cyc = 0; cyc < 72; cyc++) begin
            if (cyc < 30) begin
                ne[0] = 4'b0101; ne[1] = 4'b1110; ne[2] = 4'b1000; ne[3] = 4'b1111;
            end else begin
                ne[0] = 4'b0010; ne[1] = 4'b1001; ne[2] = 4'b0001; ne[3] = 4'b1111;
            end
            for (int p = 0; p < 4; p++) begin
                ne_drv[p] = ne[p];
                ready_drv[p] = ((cyc + p) % 4 != 0);
                bus.empty[p*4 +: 4] = ~ne[p];
            end
            bus.out_ready = ready_drv;
            step();
            for (int p = 0; p < 4; p++) begin
                was_idle = !busy[p];
                if (valid_prev[p] && ready_drv[p]) busy[p] = 1'b0;
                exp_en = was_idle && (ne_drv[p] != 4'b0000);
                n_cmp++; if (bus.rd_en[p] !== exp_en) begin n_err++; $display("FAIL mp_rd_en p%0d c%0d: got %b expected %b", p, cyc, bus.rd_en[p], exp_en); end
                n_cmp++; if (bus.out_valid[p] !== busy[p]) begin n_err++; $display("FAIL mp_valid p%0d c%0d: got %b expected %b", p, cyc, bus.out_valid[p], busy[p]); end
                if (busy[p] && bus.out_valid[p]) begin
                    n_cmp++; if (bus.out_data[p*8 +: 8] !== exp_data[p] || bus.out_src[p*2 +: 2] !== exp_src[p]) begin
                        n_err++; $display("FAIL mp_data p%0d c%0d: got %h/%0d expected %h/%0d", p, cyc, bus.out_data[p*8 +: 8], bus.out_src[p*2 +: 2], exp_data[p], exp_src[p]);
                    end
                end
                if (exp_en) begin
                    g = ref_pick(ne_drv[p], ptr[p]);
                    n_cmp++; if (bus.rd_sel[p*2 +: 2] !== 2'(g)) begin n_err++; $display("FAIL mp_grant p%0d c%0d: got %0d expected %0d", p, cyc, bus.rd_sel[p*2 +: 2], g); end
                    ptr[p]      = (g + 1) % 4;
                    busy[p]     = 1'b1;
                    exp_src[p]  = 2'(g);
                    exp_data[p] = {4'(p), 2'b00, 2'(g)};
                    bus.port_out[p*8 +: 8] = exp_data[p];
                    grants[p]++;
                end
                valid_prev[p] = bus.out_valid[p];
            end
        end
        for (int p = 0; p < 4; p++) begin
            n_cmp++; if (grants[p] < 10) begin n_err++; $display("FAIL mp_progress p%0d: got %0d grants expected >= 10", p, grants[p]); end
        end
    endtask

    initial begin
        bus.empty     = '1;
        bus.port_out  = '0;
        bus.out_ready = '1;
        test_reset();
        test_idle_no_traffic();
        test_single_read();
        test_rr_order();
        test_back_pressure();
        test_reset_in_wait();
        test_all_ports();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
